// File: rtl/uart8_transmitter.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART8_TX_PARITY_EN to compile in the parity bit (sense set by PARITY_ODD).
module uart8_transmitter #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] in,
  output logic       out,
  output logic       busy,
  output logic       done
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (OVERSAMPLE < 2 || OVERSAMPLE > 256 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
    $error("uart8_transmitter: illegal parameter value");
  end

`ifdef UART8_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START_BIT = 3'd1, DATA_BITS = 3'd2, PARITY_BIT = 3'd3, STOP_BIT = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START_BIT = 3'd1, DATA_BITS = 3'd2, STOP_BIT = 3'd4
  } state_t;
`endif

  state_t          r_state, w_state_next;
  logic [TW-1:0]   r_tick, w_tick_next;
  logic [2:0]      r_bit_idx, w_bit_idx_next;
  logic [7:0]      r_shift, w_shift_next;
  logic            r_stop_cnt, w_stop_cnt_next;
  logic            r_out, w_out_next;
  logic            r_busy, w_busy_next;
  logic            r_done, w_done_next;
  logic            w_wrap;
  logic            w_load;
`ifdef UART8_TX_PARITY_EN
  logic            r_parity, w_parity_next;
`endif

  assign w_wrap = (r_tick == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tick     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_stop_cnt <= 1'b0;
      r_out      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART8_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_tick     <= w_tick_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_out      <= w_out_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
`ifdef UART8_TX_PARITY_EN
      r_parity   <= w_parity_next;
`endif
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_tick_next     = r_tick;
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_stop_cnt_next = r_stop_cnt;
    w_out_next      = r_out;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;
    w_load          = 1'b0;
`ifdef UART8_TX_PARITY_EN
    w_parity_next   = r_parity;
`endif

    if (!en) begin
      w_state_next    = IDLE;
      w_tick_next     = '0;
      w_bit_idx_next  = '0;
      w_shift_next    = '0;
      w_stop_cnt_next = 1'b0;
      w_out_next      = 1'b1;
      w_busy_next     = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_out_next  = 1'b1;
          w_busy_next = 1'b0;
          w_load      = start;
        end
        START_BIT: begin
          if (w_wrap) begin
            w_tick_next    = '0;
            w_out_next     = r_shift[0];
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_bit_idx_next = '0;
            w_state_next   = DATA_BITS;
          end else begin
            w_tick_next = r_tick + TW'(1);
          end
        end
        DATA_BITS: begin
          if (w_wrap) begin
            w_tick_next = '0;
            if (r_bit_idx == 3'd7) begin
`ifdef UART8_TX_PARITY_EN
              w_out_next   = r_parity;
              w_state_next = PARITY_BIT;
`else
              w_out_next      = 1'b1;
              w_stop_cnt_next = 1'b0;
              w_state_next    = STOP_BIT;
`endif
            end else begin
              w_out_next     = r_shift[0];
              w_shift_next   = {1'b0, r_shift[7:1]};
              w_bit_idx_next = r_bit_idx + 3'd1;
            end
          end else begin
            w_tick_next = r_tick + TW'(1);
          end
        end
`ifdef UART8_TX_PARITY_EN
        PARITY_BIT: begin
          if (w_wrap) begin
            w_tick_next     = '0;
            w_out_next      = 1'b1;
            w_stop_cnt_next = 1'b0;
            w_state_next    = STOP_BIT;
          end else begin
            w_tick_next = r_tick + TW'(1);
          end
        end
`endif
        STOP_BIT: begin
          if (w_wrap) begin
            w_tick_next = '0;
            if (r_stop_cnt == STOP_LAST) begin
              // A start on the final stop edge chains the next frame with no idle gap.
              w_done_next = 1'b1;
              if (start) begin
                w_load = 1'b1;
              end else begin
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
              end
            end else begin
              w_stop_cnt_next = 1'b1;
            end
          end else begin
            w_tick_next = r_tick + TW'(1);
          end
        end
        default: begin
          w_state_next    = IDLE;
          w_tick_next     = '0;
          w_bit_idx_next  = '0;
          w_stop_cnt_next = 1'b0;
          w_out_next      = 1'b1;
          w_busy_next     = 1'b0;
        end
      endcase

      if (w_load) begin
        w_shift_next    = in;
        w_tick_next     = '0;
        w_bit_idx_next  = '0;
        w_stop_cnt_next = 1'b0;
        w_out_next      = 1'b0;
        w_busy_next     = 1'b1;
        w_state_next    = START_BIT;
`ifdef UART8_TX_PARITY_EN
        w_parity_next   = (^in) ^ 1'(PARITY_ODD);
`endif
      end
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_uart8_transmitter.sv
// Bench for uart8_transmitter: frame table, hand corner-case sequences, and random traffic
// checked every cycle against a frame-position reference model.
module tb_uart8_transmitter;

  localparam int OS  = 16;
  localparam int OS2 = 8;
`ifdef UART8_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FL1 = (10 + PBITS) * OS;
  localparam int FL2 = (11 + PBITS) * OS2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       out, busy, done;
  logic       en2 = 1'b0, start2 = 1'b0;
  logic [7:0] din2 = 8'h00;
  logic       out2, busy2, done2;
  logic       chk_en = 1'b0;
  int         vectors = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart8_transmitter #(.OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .in(din),
    .out(out), .busy(busy), .done(done));

  uart8_transmitter #(.OVERSAMPLE(OS2), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .start(start2), .in(din2),
    .out(out2), .busy(busy2), .done(done2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected line level in bit slot j of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int j, input logic par_odd);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (PBITS == 1 && j == 9) return (^d) ^ par_odd;
    return 1'b1;
  endfunction

  // Reference model: position within the current frame, frame as a bit list.
  typedef struct packed {
    logic        active;
    logic [31:0] pos;
    logic [31:0] len;
    logic [11:0] bits;
    logic        out;
    logic        busy;
    logic        done;
  } mstate_t;

  function automatic mstate_t m_idle();
    mstate_t s;
    s = '0;
    s.out = 1'b1;
    return s;
  endfunction

  function automatic mstate_t m_load(input logic [7:0] d);
    mstate_t s;
    s = '0;
    for (int j = 0; j < 12; j++) s.bits[j] = exp_bit(d, j, 1'b0);
    s.len    = 32'((10 + PBITS) * OS);
    s.active = 1'b1;
    s.busy   = 1'b1;
    s.out    = 1'b0;
    return s;
  endfunction

  function automatic mstate_t m_step(input mstate_t s, input logic e, input logic st,
                                     input logic [7:0] d);
    mstate_t n;
    n = s;
    n.done = 1'b0;
    if (!e) begin
      n = m_idle();
    end else if (!s.active) begin
      if (st) n = m_load(d);
      else    n = m_idle();
    end else begin
      n.pos = s.pos + 1;
      if (n.pos == s.len) begin
        if (st) n = m_load(d);
        else    n = m_idle();
        n.done = 1'b1;
      end else begin
        n.out = s.bits[n.pos / OS];
      end
    end
    return n;
  endfunction

  mstate_t m;
  always @(posedge clk or posedge reset) begin
    if (reset) m <= m_idle();
    else       m <= m_step(m, en, start, din);
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("model_out", 32'(out), 32'(m.out));
      check("model_busy", 32'(busy), 32'(m.busy));
      check("model_done", 32'(done), 32'(m.done));
    end
    if (done)  $display("dut  frame complete t=%0t", $time);
    if (done2) $display("dut2 frame complete t=%0t", $time);
  end

  // Sends one frame on dut from idle; pokes in/start mid-frame, which must be ignored.
  task automatic send_frame(input logic [7:0] d, output int len, output logic [11:0] slots);
    din = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len = -1;
    slots = '0;
    for (int k = 0; k < FL1 + 40; k++) begin
      if (done) begin
        len = k;
        break;
      end
      if (k % OS == OS / 2) slots[k / OS] = out;
      if (k == 40) din = 8'($urandom);
      if (k == 50) start = 1'b1;
      if (k == 51) start = 1'b0;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          len;
    logic [11:0] slots;

    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'h07, 1'b1};
    tbl[2] = '{8'h3C, 1'b0};
    tbl[3] = '{8'h00, 1'b0};
    tbl[4] = '{8'hFF, 1'b0};
    tbl[5] = '{8'h80, 1'b1};
    tbl[6] = '{8'h01, 1'b1};

    // Reset is asynchronous: outputs settle before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("reset_out", 32'(out), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_out2", 32'(out2), 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    en = 1'b1;
    en2 = 1'b1;
    chk_en = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check("idle_out", 32'(out), 1);
    end

    // Table of single frames.
    foreach (tbl[i]) begin
      send_frame(tbl[i].data, len, slots);
      check("frame_len", 32'(len), 32'(FL1));
      for (int j = 0; j < 10 + PBITS; j++)
        check("frame_slot", 32'(slots[j]), 32'(exp_bit(tbl[i].data, j, 1'b0)));
`ifdef UART8_TX_PARITY_EN
      check("parity_bit", 32'(slots[9]), 32'(tbl[i].par));
`endif
      repeat (3) @(negedge clk);
    end

    // Back-to-back: start held, in swapped to 0xC3 just before the first done edge.
    din = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 2 * FL1; k++) begin
      check("b2b_done", 32'(done), 32'(k == FL1 || k == 2 * FL1));
      if (k < 2 * FL1) check("b2b_busy", 32'(busy), 1);
      if (k % OS == OS / 2) begin
        if (k < FL1) check("b2b_slot1", 32'(out), 32'(exp_bit(8'h3C, k / OS, 1'b0)));
        else         check("b2b_slot2", 32'(out), 32'(exp_bit(8'hC3, (k - FL1) / OS, 1'b0)));
      end
      if (k == 70) din = 8'h99;
      if (k == FL1 - 1) din = 8'hC3;
      if (k == FL1) start = 1'b0;
      @(negedge clk);
    end
    check("b2b_idle_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);

    // Abort: en sampled low on edge 70 of a frame.
    din = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (69) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_out", 32'(out), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    repeat (20) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 0);
    end
    en = 1'b1;
    @(negedge clk);
    send_frame(8'h01, len, slots);
    check("post_abort_len", 32'(len), 32'(FL1));
    for (int j = 0; j < 10 + PBITS; j++)
      check("post_abort_slot", 32'(slots[j]), 32'(exp_bit(8'h01, j, 1'b0)));

    // Two stop bits, oversample 8, odd parity when compiled in.
    din2 = 8'hFF;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k <= FL2 + 4; k++) begin
      check("s2_out", 32'(out2), 32'(exp_bit(8'hFF, k / OS2, 1'b1)));
      check("s2_done", 32'(done2), 32'(k == FL2));
      check("s2_busy", 32'(busy2), 32'(k < FL2));
      @(negedge clk);
    end
    din2 = 8'h07;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k <= FL2 + 2; k++) begin
      if (k % OS2 == OS2 / 2) check("s2_07_slot", 32'(out2), 32'(exp_bit(8'h07, k / OS2, 1'b1)));
      check("s2_07_done", 32'(done2), 32'(k == FL2));
      @(negedge clk);
    end

    // Random traffic against the model, including random en drops.
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(7) == 0);
      din = 8'($urandom);
      en = ($urandom_range(299) != 0);
      @(negedge clk);
    end
    en = 1'b1;
    start = 1'b0;
    repeat (FL1 + 10) @(negedge clk);

    // Reset asserted mid-frame, between clock edges.
    din = 8'hAA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_out", 32'(out), 1);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (50) begin
      @(negedge clk);
      check("post_reset_idle", 32'(out), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
